// File: rtl/mem_pkg.sv
`default_nettype none
// =====================================================================
// mem_pkg: store size encodings and per-store lane payload type. Rev 1.0
// =====================================================================
package mem_pkg;

    localparam logic [1:0] SIZE_W   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_B   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    // Lane payload of a queued store; the address is added by the queue
    // so that its width can follow the AW parameter.
    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
    } store_lane_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/store_lane_pack.sv
`default_nettype none
// =====================================================================
// store_lane_pack: narrows register data to byte/half/word lanes. Rev 1.0
// =====================================================================
module store_lane_pack
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        err
);

    always_comb begin
        wdata = 32'h0;
        be    = 4'b0000;
        err   = 1'b0;
        case (size)
            SIZE_B: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            SIZE_H: begin
                if (!addr_lo[0]) begin
                    wdata = {2{data[15:0]}};
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                end else begin
                    err = 1'b1;
                end
            end
            SIZE_W: begin
                if (addr_lo == 2'b00) begin
                    wdata = data;
                    be    = 4'b1111;
                end else begin
                    err = 1'b1;
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule : store_lane_pack
`default_nettype wire

// File: rtl/store_queue.sv
`default_nettype none
// =====================================================================
// store_queue: packs stores into lanes and buffers them for memory. Rev 1.0
// =====================================================================
module store_queue
    import mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [31:0]                in_data,
    input  logic [1:0]                 in_size,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [AW-1:0]              out_addr,
    output logic [31:0]                out_wdata,
    output logic [3:0]                 out_be,
    output logic                       out_err,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        store_lane_t   lane;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_err;
    logic        w_push;
    logic        w_pop;
    entry_t      w_new;
    entry_t      w_head;

    store_lane_pack u_pack (
        .addr_lo (in_addr[1:0]),
        .data    (in_data),
        .size    (in_size),
        .wdata   (w_wdata),
        .be      (w_be),
        .err     (w_err)
    );

    assign in_ready  = (r_count < C_DEPTH);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_new.addr       = {in_addr[AW-1:2], 2'b00};
    assign w_new.lane.wdata = w_wdata;
    assign w_new.lane.be    = w_be;
    assign w_new.lane.err   = w_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            // Storage is cleared so the head outputs read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_new;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign out_addr  = w_head.addr;
    assign out_wdata = w_head.lane.wdata;
    assign out_be    = w_head.lane.be;
    assign out_err   = w_head.lane.err;
    assign count     = r_count;

endmodule : store_queue
`default_nettype wire

// File: doc/store_queue.md
Name: store_queue

Overview:
- Memory-stage store path: the reverse of immediate/load extension. It narrows 32-bit register data to byte/half/word lanes.
- Produces byte-enables and a word-aligned address.
- Buffers up to DEPTH stores between the pipeline (producer) and the data-memory write port (consumer) using valid/ready handshakes on both sides.
- Misaligned or reserved-size stores are flagged in order, never written.

Parameters:
- DEPTH, 2, number of buffered store entries (power of two, ≥2).
- AW, 32, address width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  store request present.
- in_ready  output  1  queue can accept this cycle.
- in_addr  input  AW  byte address of the store.
- in_data  input  32  register (rt) value.
- in_size  input  2  00 = sw, 01 = sh, 10 = sb, 11 = reserved.
- out_valid  output  1  head entry present.
- out_ready  input  1  memory accepts head this cycle.
- out_addr  output  AW  {in_addr[AW-1:2], 2'b00} of the head entry.
- out_wdata  output  32  lane-replicated write data.
- out_be  output  4  byte enables; bit k = byte addr[1:0]==k (little-endian).
- out_err  output  1  head entry is misaligned or reserved-size; out_be = 0.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (reset==0 at posedge):
  - count=0, read/write pointers=0.
  - out_valid=0, out_addr=0, out_wdata=0, out_be=0, out_err=0.
  - Reset mid-operation discards all entries, including a handshake in the same cycle.
- Push when in_valid&&in_ready. Pop when out_valid&&out_ready.
- in_ready = (count<DEPTH). It does not depend on out_ready: full plus a pop in the same cycle still refuses the push.
- out_valid = (count!=0).
- Outputs come from registered storage only. Latency is exactly one cycle from accept to out_valid; there is no same-cycle bypass when empty.
- Packing is computed at push time, with a = in_addr[1:0]:
  - sb: wdata = {4{in_data[7:0]}}, be = 4'b0001<<a.
  - sh: a[0]==0 → wdata = {2{in_data[15:0]}}, be = a[1] ? 4'b1100 : 4'b0011. a[0]==1 → err.
  - sw: a==00 → wdata = in_data, be = 4'b1111. a!=00 → err.
  - size 11 → err.
  - err entries: be = 4'b0000, wdata = 0, err = 1. They are still enqueued and popped in program order.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Pop when empty and push when full are impossible by construction. No state change occurs on the non-handshaking side.
- Head outputs hold stable while out_valid&&!out_ready.

Decomposition:
- Shared package (mem_pkg): SIZE_W=2'b00, SIZE_H=2'b01, SIZE_B=2'b10, SIZE_RSV=2'b11; the entry struct {addr, wdata, be, err}.
- Sub-module store_lane_pack: combinational packer (addr[1:0], data, size → wdata, be, err). It is instantiated once on the push path.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0. Push during reset → no entry.
- sb, addr=0x0000_1003, data=0x1234_56AB → next cycle: out_addr=0x0000_1000, out_wdata=0xABAB_ABAB, out_be=4'b1000, out_err=0.
- sh, addr=0x2002, data=0xFFFF_BEEF → out_wdata=0xBEEF_BEEF, out_be=4'b1100. sh at addr=0x2001 → out_err=1, out_be=0.
- Fill with out_ready=0 (sw 0x10=0x11111111, sw 0x14=0x22222222):
  - count=2, in_ready=0, and a third push is refused even when out_ready is raised that cycle.
  - Pops return the entries in order.
- Continuous push+pop, 8 sw at consecutive addresses → data order preserved across pointer wrap, count never exceeds 1.
- Assert reset with 2 entries queued and out_ready=1 → next cycle count=0, out_valid=0, no extra pop observed.
